mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage of the pipeline, directly downstream of EX_MEM. Consumes the MEM_* control bits plus the EX result, store data and destination register. Performs data-RAM byte/word reads and writes, then registers the writeback value and control into the MEM/WB boundary, producing WB_* signals for the register file. It also exposes the pre-register result combinationally for the forwarding logic.

Parameters:
ADDR_W, 8, data-RAM address width in bytes (2^ADDR_W bytes).
DATA_W, 32, datapath width; fixed at 32, ARM word.

Ports:
clk  in  1  pipeline clock, rising-edge
R  in  1  synchronous active-high reset
MEM_load_instr  in  1  1 = writeback takes RAM read data, 0 = takes ALU result
MEM_RF_enable  in  1  register-file write enable travelling to WB
MEM_Size_enable  in  1  1 = word access, 0 = byte access
MEM_RW_enable  in  1  1 = write (store), 0 = read
MEM_Enable_signal  in  1  data-RAM access enable
MEM_alu_result  in  32  effective address / ALU result
MEM_store_data  in  32  store source register value
MEM_rd  in  4  destination register number
MEM_fwd_data  out  32  combinational writeback value of the current MEM instruction
WB_RF_enable  out  1  registered RF write enable
WB_rd  out  4  registered destination register
WB_data  out  32  registered writeback data

Behaviour:
- Clock is clk; reset R is synchronous and active-high, sampled only on the rising edge of clk.
- Reset: on a rising edge with R=1, WB_RF_enable=0, WB_rd=0, WB_data=0x00000000. RAM contents are not cleared. Any store presented in that cycle is suppressed.
- Address: addr = MEM_alu_result[ADDR_W-1:0]. Upper bits are ignored, so accesses wrap modulo 2^ADDR_W.
- Word accesses ignore addr[1:0] and use the aligned-down address. Byte accesses use the full addr.
- Byte order is big-endian: byte at aligned address A is word bits [31:24], A+3 is bits [7:0].
- Read is combinational from the current RAM contents and is active when MEM_Enable_signal=1 and MEM_RW_enable=0.
  - Word read returns 4 bytes.
  - Byte read returns the byte zero-extended to 32 bits.
  - With Enable=0, read data = 0.
- Write happens on the rising edge when MEM_Enable_signal=1, MEM_RW_enable=1 and R=0.
  - Word write stores all 4 bytes of MEM_store_data.
  - Byte write stores MEM_store_data[7:0] only; other bytes are untouched.
- Writeback select: MEM_fwd_data = MEM_load_instr ? read data : MEM_alu_result.
- Illegal load_instr=1 with RW=1: read data is the pre-write RAM contents at the same address. The write still occurs.
- MEM/WB register: on each rising edge with R=0, WB_RF_enable<=MEM_RF_enable, WB_rd<=MEM_rd, WB_data<=MEM_fwd_data. There is no stall or enable input; it updates every cycle.
- Latency:
  - Store visible to a load in the following cycle (read-after-write, distance 1): yes.
  - Load result on WB_data: 1 cycle after the instruction occupies MEM.
- Reset mid-operation: pipeline outputs zero on that edge; the RAM holds whatever was written before the reset edge.

Decomposition:
- Shared package: access-size constants SIZE_BYTE=0 and SIZE_WORD=1, RW_READ=0 and RW_WRITE=1, and the DATA_W and register-index width (4).
- One sub-module, data_ram:
  - byte array of 2^ADDR_W entries
  - synchronous write port and combinational read port
  - big-endian packing and zero-extension
- mem_stage instantiates data_ram and holds the MEM/WB register and the writeback mux.

Test Plan:
1. Word store 0xDEADBEEF at addr 0x10 (Enable=1, RW=1, Size=1), then word load 0x12 with load_instr=1, RF=1, rd=5 -> next edge WB_data=0xDEADBEEF, WB_rd=5, WB_RF_enable=1.
2. After scenario 1: byte load 0x10 -> WB_data=0x000000DE; byte load 0x13 -> WB_data=0x000000EF.
3. Byte store 0x55 (store_data=0xAABBCC55) at 0x11, then word load 0x10 -> WB_data=0xDE55BEEF.
4. Non-memory op: Enable=0, load_instr=0, RF=1, alu_result=0x00001234, rd=3 -> MEM_fwd_data=0x00001234 the same cycle; next edge WB_data=0x00001234, WB_rd=3. RAM unchanged.
5. R=1 with a word store 0xFFFFFFFF at 0x10 presented -> WB_* all 0. A subsequent word load 0x10 returns the prior contents (0xDE55BEEF).
6. Wrap (ADDR_W=8): byte store 0x7A at alu_result=0x000001FF -> byte load 0xFF returns 0x0000007A. Word load at 0x1FE returns the aligned word at 0xFC.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared access-size/direction encodings and datapath widths
package mem_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 4;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM control+data into the memory stage and MEM/WB results out
interface mem_stage_if;
  import mem_stage_pkg::*;
  logic              MEM_load_instr;
  logic              MEM_RF_enable;
  logic              MEM_Size_enable;
  logic              MEM_RW_enable;
  logic              MEM_Enable_signal;
  logic [DATA_W-1:0] MEM_alu_result;
  logic [DATA_W-1:0] MEM_store_data;
  logic [REG_W-1:0]  MEM_rd;
  logic [DATA_W-1:0] MEM_fwd_data;
  logic              WB_RF_enable;
  logic [REG_W-1:0]  WB_rd;
  logic [DATA_W-1:0] WB_data;
  modport master (
    output MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable,
           MEM_Enable_signal, MEM_alu_result, MEM_store_data, MEM_rd,
    input  MEM_fwd_data, WB_RF_enable, WB_rd, WB_data
  );
  modport slave (
    input  MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable,
           MEM_Enable_signal, MEM_alu_result, MEM_store_data, MEM_rd,
    output MEM_fwd_data, WB_RF_enable, WB_rd, WB_data
  );
endinterface

// File: rtl/mem_stage_data_ram.sv
// data_ram: big-endian byte-addressed RAM, synchronous write, combinational read
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic              word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-3:0] wa;
  assign wa = addr[ADDR_W-1:2];
  always_ff @(posedge clk) begin
    if (we && word == SIZE_WORD) begin
      mem[{wa, 2'd0}] <= wdata[31:24];
      mem[{wa, 2'd1}] <= wdata[23:16];
      mem[{wa, 2'd2}] <= wdata[15:8];
      mem[{wa, 2'd3}] <= wdata[7:0];
    end else if (we) begin
      mem[addr] <= wdata[7:0];
    end
  end
  // read sees pre-edge contents, so a load paired with a store returns the old data
  always_comb begin
    rdata = !re ? '0
          : word == SIZE_WORD ? {mem[{wa, 2'd0}], mem[{wa, 2'd1}], mem[{wa, 2'd2}], mem[{wa, 2'd3}]}
          : {24'd0, mem[addr]};
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-RAM access, writeback select and the MEM/WB pipeline register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic R,
  mem_stage_if.slave bus
);
  logic [DATA_W-1:0] rd_data;
  logic              we;
  logic              wb_rf_enable_d, wb_rf_enable_q;
  logic [REG_W-1:0]  wb_rd_d, wb_rd_q;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  assign we = bus.MEM_Enable_signal && bus.MEM_RW_enable == RW_WRITE && !R;
  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .re    (bus.MEM_Enable_signal),
    .word  (bus.MEM_Size_enable),
    .addr  (bus.MEM_alu_result[ADDR_W-1:0]),
    .wdata (bus.MEM_store_data),
    .rdata (rd_data)
  );
  always_comb begin
    wb_data_d = bus.MEM_load_instr ? rd_data : bus.MEM_alu_result;
    wb_rf_enable_d = bus.MEM_RF_enable;
    wb_rd_d = bus.MEM_rd;
  end
  always_ff @(posedge clk) begin
    if (R) begin
      wb_rf_enable_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_rf_enable_q <= wb_rf_enable_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end
  assign bus.MEM_fwd_data = wb_data_d;
  assign bus.WB_RF_enable = wb_rf_enable_q;
  assign bus.WB_rd = wb_rd_q;
  assign bus.WB_data = wb_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plan plus randomized traffic against a byte-array model
module tb_mem_stage;
  logic clk = 1'b0;
  logic R = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem_m [256];
  mem_stage_if bus ();
  mem_stage #(.ADDR_W(8)) dut (.clk(clk), .R(R), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mref(input logic [31:0] alu, input logic sz, input logic en);
    logic [7:0] a = alu[7:0];
    logic [7:0] b = alu[7:0] & 8'hFC;
    if (!en) return 32'd0;
    if (sz) return {mem_m[b], mem_m[b + 8'd1], mem_m[b + 8'd2], mem_m[b + 8'd3]};
    return {24'd0, mem_m[a]};
  endfunction
  task automatic mwrite(input logic [31:0] alu, input logic [31:0] sd, input logic sz);
    logic [7:0] a = alu[7:0];
    logic [7:0] b = alu[7:0] & 8'hFC;
    if (sz) begin
      mem_m[b] = sd[31:24];
      mem_m[b + 8'd1] = sd[23:16];
      mem_m[b + 8'd2] = sd[15:8];
      mem_m[b + 8'd3] = sd[7:0];
    end else mem_m[a] = sd[7:0];
  endtask
  task automatic step(input logic r, input logic ld, input logic rf, input logic sz,
                      input logic rw, input logic en, input logic [31:0] alu,
                      input logic [31:0] sd, input logic [3:0] rd);
    logic [31:0] fwd;
    R = r;
    bus.MEM_load_instr = ld;
    bus.MEM_RF_enable = rf;
    bus.MEM_Size_enable = sz;
    bus.MEM_RW_enable = rw;
    bus.MEM_Enable_signal = en;
    bus.MEM_alu_result = alu;
    bus.MEM_store_data = sd;
    bus.MEM_rd = rd;
    fwd = ld ? mref(alu, sz, en) : alu;
    #2;
    check("fwd", bus.MEM_fwd_data, fwd);
    if (en && rw && !r) mwrite(alu, sd, sz);
    @(posedge clk);
    #1;
    check("wb_data", bus.WB_data, r ? 32'd0 : fwd);
    check("wb_rd", {28'd0, bus.WB_rd}, r ? 32'd0 : {28'd0, rd});
    check("wb_rf", {31'd0, bus.WB_RF_enable}, r ? 32'd0 : {31'd0, rf});
  endtask
  initial begin
    bus.MEM_load_instr = 0;
    bus.MEM_RF_enable = 1;
    bus.MEM_Size_enable = 1;
    bus.MEM_RW_enable = 0;
    bus.MEM_Enable_signal = 0;
    bus.MEM_alu_result = 32'h1234_5678;
    bus.MEM_store_data = 0;
    bus.MEM_rd = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_data", bus.WB_data, 32'd0);
    check("rst_rd", {28'd0, bus.WB_rd}, 32'd0);
    check("rst_rf", {31'd0, bus.WB_RF_enable}, 32'd0);
    for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 1, 1, 32'(i * 4), 32'd0, 4'd0);
    step(0, 0, 0, 1, 1, 1, 32'h10, 32'hDEADBEEF, 4'd0);
    step(0, 1, 1, 1, 0, 1, 32'h12, 32'h0, 4'd5);
    check("p1_data", bus.WB_data, 32'hDEADBEEF);
    check("p1_rd", {28'd0, bus.WB_rd}, 32'd5);
    step(0, 1, 1, 0, 0, 1, 32'h10, 32'h0, 4'd1);
    check("p2_b10", bus.WB_data, 32'h000000DE);
    step(0, 1, 1, 0, 0, 1, 32'h13, 32'h0, 4'd1);
    check("p2_b13", bus.WB_data, 32'h000000EF);
    step(0, 0, 0, 0, 1, 1, 32'h11, 32'hAABBCC55, 4'd0);
    step(0, 1, 1, 1, 0, 1, 32'h10, 32'h0, 4'd2);
    check("p3_merge", bus.WB_data, 32'hDE55BEEF);
    step(0, 0, 1, 1, 0, 0, 32'h00001234, 32'h0, 4'd3);
    check("p4_alu", bus.WB_data, 32'h00001234);
    step(1, 0, 1, 1, 1, 1, 32'h10, 32'hFFFFFFFF, 4'd7);
    step(0, 1, 1, 1, 0, 1, 32'h10, 32'h0, 4'd4);
    check("p5_kept", bus.WB_data, 32'hDE55BEEF);
    step(0, 0, 0, 0, 1, 1, 32'h000001FF, 32'h0000007A, 4'd0);
    step(0, 1, 1, 0, 0, 1, 32'hFF, 32'h0, 4'd6);
    check("p6_wrap", bus.WB_data, 32'h0000007A);
    step(0, 1, 1, 1, 0, 1, 32'h1FE, 32'h0, 4'd6);
    step(0, 1, 1, 1, 1, 1, 32'h20, 32'h01020304, 4'd8);
    step(0, 1, 1, 1, 0, 1, 32'h20, 32'h0, 4'd9);
    check("raw_next", bus.WB_data, 32'h01020304);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
